// File: rtl/dfx_deframer.sv
// Reassembles fixed-size address+data packets from a stream of headed link beats.
// Header per beat: SOF, EOF and a modular beat sequence number; bad framing drops the packet.
module dfx_deframer #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int HDR_WIDTH         = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AURORA_DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [ADDR_WIDTH-1:0]        m_addr,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         err,
    output logic [15:0]                  pkt_cnt,
    output logic [15:0]                  err_cnt
);

    localparam int PKT_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int PW    = AURORA_DATA_WIDTH - HDR_WIDTH;
    localparam int NB    = (PKT_W + PW - 1) / PW;
    localparam int SW    = HDR_WIDTH - 2;
    localparam int KW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int ASM_W = NB * PW;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

    logic [1:0]       state, state_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [ASM_W-1:0] asm_buf, asm_nxt;
    logic             store, deliver, bad;
    logic [KW-1:0]    store_idx;

    logic          sof, eof, is_start, k_last, beat_ok, accept;
    logic [SW-1:0] seq;
    logic [PW-1:0] payload;

    assign sof      = s_data[HDR_WIDTH-1];
    assign eof      = s_data[HDR_WIDTH-2];
    assign seq      = s_data[SW-1:0];
    assign payload  = s_data[AURORA_DATA_WIDTH-1:HDR_WIDTH];
    assign accept   = s_valid && s_ready;
    assign is_start = sof && (seq == '0);
    assign k_last   = (k == K_LAST);
    assign beat_ok  = !sof && (seq == SW'(k)) && (eof == k_last);

    // Only the final beat of a packet needs the output register, so that is the only stall point.
    assign s_ready = !((state == ST_COLLECT) && k_last && m_valid && !m_ready);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
        state_nxt = state;
        k_nxt     = k;
        store     = 1'b0;
        store_idx = k;
        deliver   = 1'b0;
        bad       = 1'b0;

        if (flush) begin
            state_nxt = ST_IDLE;
            k_nxt     = '0;
        end else if (accept) begin
            case (state)
                ST_COLLECT: begin
                    if (beat_ok) begin
                        store = 1'b1;
                        if (k_last) begin
                            deliver   = 1'b1;
                            state_nxt = ST_IDLE;
                            k_nxt     = '0;
                        end else begin
                            k_nxt = k + KW'(1);
                        end
                    end else begin
                        bad = 1'b1;
                        if (is_start) begin
                            store     = 1'b1;
                            store_idx = '0;
                            k_nxt     = KW'(1);
                        end else begin
                            state_nxt = ST_DROP;
                            k_nxt     = '0;
                        end
                    end
                end
                default: begin
                    // IDLE and DROP both wait for a clean start-of-frame beat.
                    if (is_start) begin
                        if (NB == 1) begin
                            if (eof) begin
                                store     = 1'b1;
                                store_idx = '0;
                                deliver   = 1'b1;
                                state_nxt = ST_IDLE;
                                k_nxt     = '0;
                            end
                        end else begin
                            store     = 1'b1;
                            store_idx = '0;
                            state_nxt = ST_COLLECT;
                            k_nxt     = KW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        asm_nxt = asm_buf;
        for (int b = 0; b < NB; b++) begin
            if (store && (store_idx == KW'(b))) begin
                asm_nxt[b*PW +: PW] = payload;
            end
        end
    end

    // The packet is taken from asm_nxt so the final beat lands in the output on its own edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= ST_IDLE;
            k       <= '0;
            asm_buf <= '0;
            m_data  <= '0;
            m_addr  <= '0;
            m_valid <= 1'b0;
            err     <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            asm_buf <= asm_nxt;
            err     <= bad;

            if (deliver) begin
                m_valid <= 1'b1;
                m_data  <= asm_nxt[DATA_WIDTH-1:0];
                m_addr  <= asm_nxt[PKT_W-1:DATA_WIDTH];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (m_valid && m_ready && (pkt_cnt != 16'hFFFF)) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (bad && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
